usr_cmd_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the 4-bit universal shift register and drives its mode-select, serial-fill and parallel-data inputs.
- Accepts one command per valid/ready handshake: load, logical shift up/down by N, or rotate up/down by N.
- Reads the register's q outputs back to generate rotate fill and the serial output stream.
- Reports completion with a single-cycle done pulse.

---
 rtl/usr_cmd_sequencer.sv | 153 +++++++++++++++
 tb/tb_usr_cmd_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_cmd_sequencer.sv
// Command sequencer for the 4-bit universal shift register.
// Accepts LOAD / shift / rotate commands over a valid-ready handshake. It drives
// the register's mode, fill and parallel-data inputs, and reads q back to
// generate the rotate fill and the serial output stream.
module usr_cmd_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] q_in,
  output logic [1:0]       usr_s,
  output logic             usr_l,
  output logic             usr_r,
  output logic [WIDTH-1:0] usr_d,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] OpLoad  = 3'b001;
  localparam logic [2:0] OpShup  = 3'b010;
  localparam logic [2:0] OpShdn  = 3'b011;
  localparam logic [2:0] OpRotup = 3'b100;
  localparam logic [2:0] OpRotdn = 3'b101;

  localparam logic [1:0] ModeHold = 2'b00;
  localparam logic [1:0] ModeUp   = 2'b01;
  localparam logic [1:0] ModeDown = 2'b10;
  localparam logic [1:0] ModeLoad = 2'b11;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [2:0]       op_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       usr_s_q, usr_s_d;
  logic [WIDTH-1:0] usr_d_q;
  logic             accept;
  logic             cmd_is_shift;
  logic             nxt_is_up;
  logic             op_is_up;
  logic             op_is_down;

  assign cmd_ready = (state_q == StIdle) && rst;
  assign accept    = cmd_valid && cmd_ready;

  assign cmd_is_shift = (cmd_op == OpShup) || (cmd_op == OpShdn) ||
                        (cmd_op == OpRotup) || (cmd_op == OpRotdn);

  // Opcode that will be held in op_q after this edge; lets usr_s be registered
  // so it is already correct in the first cycle after accept.
  assign op_nxt    = accept ? cmd_op : op_q;
  assign nxt_is_up = (op_nxt == OpShup) || (op_nxt == OpRotup);

  assign op_is_up   = (op_q == OpShup) || (op_q == OpRotup);
  assign op_is_down = (op_q == OpShdn) || (op_q == OpRotdn);

  // State register; reset aborts any command in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_op == OpLoad) begin
            state_d = StLoad;
          end else if (cmd_is_shift && (cmd_count != '0)) begin
            state_d = StShift;
          end else begin
            state_d = StDone;
          end
        end
      end
      StLoad:  state_d = StDone;
      StShift: if (cnt_q == CNT_W'(1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered mode select derived from the state being entered.
  always_comb begin
    usr_s_d = ModeHold;
    case (state_d)
      StLoad:  usr_s_d = ModeLoad;
      StShift: usr_s_d = nxt_is_up ? ModeUp : ModeDown;
      default: usr_s_d = ModeHold;
    endcase
  end

  // Command latch, step counter and registered register-control outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q    <= '0;
      cnt_q   <= '0;
      usr_s_q <= ModeHold;
      usr_d_q <= '0;
    end else begin
      usr_s_q <= usr_s_d;
      if (accept) begin
        op_q  <= cmd_op;
        cnt_q <= cmd_count;
        if (cmd_op == OpLoad) begin
          usr_d_q <= cmd_data;
        end
      end else if (state_q == StShift) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Fill bits, serial stream and completion flags.
  always_comb begin
    usr_l         = 1'b0;
    usr_r         = 1'b0;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;
    if (state_q == StShift) begin
      ser_out_valid = 1'b1;
      if (op_is_up) begin
        usr_r   = (op_q == OpRotup) ? q_in[WIDTH-1] : ser_in;
        ser_out = q_in[WIDTH-1];
      end else if (op_is_down) begin
        usr_l   = (op_q == OpRotdn) ? q_in[0] : ser_in;
        ser_out = q_in[0];
      end
    end
    done = (state_q == StDone);
    // Opcodes 110/111 are consumed like NOP but flagged on completion.
    err  = (state_q == StDone) && (op_q[2:1] == 2'b11);
  end

  assign usr_s = usr_s_q;
  assign usr_d = usr_d_q;

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Directed bench for usr_cmd_sequencer with a behavioural 4-bit universal
// shift register closing the q feedback loop.
module tb_usr_cmd_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic [1:0]       usr_s;
  logic             usr_l;
  logic             usr_r;
  logic [WIDTH-1:0] usr_d;
  logic             ser_out;
  logic             ser_out_valid;
  logic             done;
  logic             err;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  usr_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_count     (cmd_count),
    .cmd_data      (cmd_data),
    .ser_in        (ser_in),
    .q_in          (q),
    .usr_s         (usr_s),
    .usr_l         (usr_l),
    .usr_r         (usr_r),
    .usr_d         (usr_d),
    .ser_out       (ser_out),
    .ser_out_valid (ser_out_valid),
    .done          (done),
    .err           (err)
  );

  // Behavioural universal shift register (not reset by the sequencer reset).
  initial q = 4'b0000;
  always @(posedge clk) begin
    case (usr_s)
      2'b01:   q <= {q[2:0], usr_r};
      2'b10:   q <= {usr_l, q[3:1]};
      2'b11:   q <= usr_d;
      default: q <= q;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] val);
    cmd_valid = 1'b1;
    cmd_op    = 3'b001;
    cmd_data  = val;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 3'b001;
    cmd_data  = 4'b0101;
    cmd_count = '0;
    ser_in    = 1'b0;
    tick(); tick(); tick();
    vecs++;
    if ({cmd_ready, usr_s, usr_l, usr_r, usr_d, ser_out, ser_out_valid, done, err} !== 13'd0) begin
      errs++;
      $display("FAIL reset_outputs: got %b required 0",
               {cmd_ready, usr_s, usr_l, usr_r, usr_d, ser_out, ser_out_valid, done, err});
    end
    rst = 1'b1;
    #1;
    vecs++;
    if (cmd_ready !== 1'b1 || usr_s !== 2'b00) begin
      errs++;
      $display("FAIL reset_release_ready: ready=%b usr_s=%b required 1/00", cmd_ready, usr_s);
    end
    tick();
    vecs++;
    if (usr_s !== 2'b11 || cmd_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_first_accept: usr_s=%b ready=%b required 11/0", usr_s, cmd_ready);
    end
    cmd_valid = 1'b0;
    tick();
    vecs++;
    if (q !== 4'b0101 || done !== 1'b1) begin
      errs++;
      $display("FAIL reset_first_load: q=%b done=%b required 0101/1", q, done);
    end
    tick();
  endtask

  task automatic test_load();
    vecs++;
    if (cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL load_ready_before: got %b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = 3'b001;
    cmd_data  = 4'b1011;
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 4'b0000;
    vecs++;
    if (usr_s !== 2'b11 || usr_d !== 4'b1011 || done !== 1'b0 || cmd_ready !== 1'b0) begin
      errs++;
      $display("FAIL load_cycle: usr_s=%b usr_d=%b done=%b ready=%b required 11/1011/0/0",
               usr_s, usr_d, done, cmd_ready);
    end
    tick();
    vecs++;
    if (q !== 4'b1011 || done !== 1'b1 || usr_s !== 2'b00 || cmd_ready !== 1'b0) begin
      errs++;
      $display("FAIL load_done: q=%b done=%b usr_s=%b ready=%b required 1011/1/00/0",
               q, done, usr_s, cmd_ready);
    end
    tick();
    vecs++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || usr_d !== 4'b1011) begin
      errs++;
      $display("FAIL load_after: done=%b ready=%b usr_d=%b required 0/1/1011",
               done, cmd_ready, usr_d);
    end
  endtask

  task automatic test_rotup();
    logic [4:0] exp_ser;
    exp_ser   = 5'b11101;
    cmd_valid = 1'b1;
    cmd_op    = 3'b100;
    cmd_count = 3'd5;
    tick();
    cmd_valid = 1'b0;
    cmd_count = 3'd0;
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (usr_s !== 2'b01 || ser_out_valid !== 1'b1 || ser_out !== exp_ser[i] || done !== 1'b0) begin
        errs++;
        $display("FAIL rotup_step%0d: usr_s=%b sov=%b ser_out=%b done=%b required 01/1/%b/0",
                 i, usr_s, ser_out_valid, ser_out, done, exp_ser[i]);
      end
      tick();
    end
    vecs++;
    if (q !== 4'b0111 || done !== 1'b1 || usr_s !== 2'b00 || ser_out_valid !== 1'b0) begin
      errs++;
      $display("FAIL rotup_end: q=%b done=%b usr_s=%b sov=%b required 0111/1/00/0",
               q, done, usr_s, ser_out_valid);
    end
    tick();
    vecs++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL rotup_idle: done=%b ready=%b required 0/1", done, cmd_ready);
    end
  endtask

  task automatic test_shdn();
    logic [5:0] exp_ser;
    int         nvalid;
    exp_ser = 6'b001011;
    nvalid  = 0;
    do_load(4'b1011);
    ser_in    = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 3'b011;
    cmd_count = 3'd6;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ser_out_valid === 1'b1) nvalid++;
      vecs++;
      if (usr_s !== 2'b10 || ser_out !== exp_ser[i] || usr_l !== 1'b0 || usr_r !== 1'b0) begin
        errs++;
        $display("FAIL shdn_step%0d: usr_s=%b ser_out=%b l=%b r=%b required 10/%b/0/0",
                 i, usr_s, ser_out, usr_l, usr_r, exp_ser[i]);
      end
      tick();
    end
    if (ser_out_valid === 1'b1) nvalid++;
    vecs++;
    if (q !== 4'b0000 || done !== 1'b1 || nvalid != 6) begin
      errs++;
      $display("FAIL shdn_end: q=%b done=%b valid_cycles=%0d required 0000/1/6", q, done, nvalid);
    end
    tick();
  endtask

  task automatic test_illegal_and_zero();
    cmd_valid = 1'b1;
    cmd_op    = 3'b111;
    tick();
    cmd_valid = 1'b0;
    vecs++;
    if (usr_s !== 2'b00 || done !== 1'b1 || err !== 1'b1 || cmd_ready !== 1'b0) begin
      errs++;
      $display("FAIL illegal_done: usr_s=%b done=%b err=%b ready=%b required 00/1/1/0",
               usr_s, done, err, cmd_ready);
    end
    tick();
    vecs++;
    if (done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL illegal_after: done=%b err=%b ready=%b required 0/0/1", done, err, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = 3'b010;
    cmd_count = 3'd0;
    ser_in    = 1'b1;
    tick();
    cmd_valid = 1'b0;
    vecs++;
    if (usr_s !== 2'b00 || done !== 1'b1 || err !== 1'b0 || ser_out_valid !== 1'b0) begin
      errs++;
      $display("FAIL zero_count: usr_s=%b done=%b err=%b sov=%b required 00/1/0/0",
               usr_s, done, err, ser_out_valid);
    end
    tick();
    vecs++;
    if (q !== 4'b0000 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL zero_after: q=%b ready=%b done=%b required 0000/1/0", q, cmd_ready, done);
    end
  endtask

  task automatic test_reset_mid();
    do_load(4'b1011);
    ser_in    = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'b010;
    cmd_count = 3'd4;
    tick();
    cmd_valid = 1'b1;
    vecs++;
    if (usr_s !== 2'b01) begin
      errs++;
      $display("FAIL midrst_shift: usr_s=%b required 01", usr_s);
    end
    rst = 1'b0;
    tick();
    vecs++;
    if (usr_s !== 2'b00 || done !== 1'b0 || cmd_ready !== 1'b0 || q !== 4'b0111) begin
      errs++;
      $display("FAIL midrst_abort: usr_s=%b done=%b ready=%b q=%b required 00/0/0/0111",
               usr_s, done, cmd_ready, q);
    end
    tick();
    vecs++;
    if (q !== 4'b0111 || done !== 1'b0 || usr_s !== 2'b00) begin
      errs++;
      $display("FAIL midrst_hold: q=%b done=%b usr_s=%b required 0111/0/00", q, done, usr_s);
    end
    rst       = 1'b1;
    cmd_op    = 3'b001;
    cmd_data  = 4'b0110;
    #1;
    vecs++;
    if (cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL midrst_ready: got %b required 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    tick();
    vecs++;
    if (q !== 4'b0110 || done !== 1'b1) begin
      errs++;
      $display("FAIL midrst_next_cmd: q=%b done=%b required 0110/1", q, done);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_rotup();
    test_shdn();
    test_illegal_and_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
